// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings for the core: opcodes, load funct3 values, the canonical NOP,
// and small decode helpers.
package riscv_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } load_f3_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_JAL, OPC_JALR, OPC_LUI,
            OPC_AUIPC, OPC_OP, OPC_OP_IMM: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc, input logic [2:0] funct3);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
            // Only register-source CSR forms (csrrw/csrrs/csrrc) read rs1.
            OPC_SYSTEM: return (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b011);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns the DMEM read word by the low address bits and sign/zero-extends the loaded value.
module load_extend
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] dmem_dout,
    output logic [31:0] load_val
);

    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        shifted  = dmem_dout >> {addr, 3'b000};
        byte_val = shifted[7:0];
        half_val = addr[1] ? dmem_dout[31:16] : dmem_dout[15:0];
        case (funct3)
            F3_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            F3_LBU:  load_val = {24'h0, byte_val};
            F3_LH:   load_val = {{16{half_val[15]}}, half_val};
            F3_LHU:  load_val = {16'h0, half_val};
            default: load_val = dmem_dout;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MW pipeline register plus writeback select, regfile write port and MW->D forwarding.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned  DWIDTH = 32,
    parameter logic [31:0]  NOP    = NOP_INST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       x2m_inst,
    input  logic [DWIDTH-1:0] x2m_pc,
    input  logic [DWIDTH-1:0] x2m_alu,
    input  logic [DWIDTH-1:0] dmem_dout,
    input  logic [31:0]       d_inst,
    output logic              wb_we,
    output logic [4:0]        wb_addr,
    output logic [DWIDTH-1:0] wb_val,
    output logic              wb2d_a,
    output logic              wb2d_b,
    output logic [31:0]       mw_inst
);

    logic [31:0]       inst_q, inst_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] alu_q, alu_d;
    logic [DWIDTH-1:0] load_val;
    logic [6:0]        opc;
    logic [4:0]        rd;
    logic              unused_d_inst;

    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        alu_d  = alu_q;
        if (flush) begin
            inst_d = NOP;
            pc_d   = '0;
            alu_d  = '0;
        end else if (!stall) begin
            inst_d = x2m_inst;
            pc_d   = x2m_pc;
            alu_d  = x2m_alu;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q <= NOP;
            pc_q   <= '0;
            alu_q  <= '0;
        end else begin
            inst_q <= inst_d;
            pc_q   <= pc_d;
            alu_q  <= alu_d;
        end
    end

    load_extend u_load_extend (
        .funct3    (inst_q[14:12]),
        .addr      (alu_q[1:0]),
        .dmem_dout (dmem_dout),
        .load_val  (load_val)
    );

    assign opc = inst_q[6:0];
    assign rd  = inst_q[11:7];

    always_comb begin
        case (opc)
            OPC_LOAD:          wb_val = load_val;
            OPC_JAL, OPC_JALR: wb_val = pc_q + DWIDTH'(4);
            default:           wb_val = alu_q;
        endcase
        wb_we   = writes_rd(opc) && (rd != 5'd0);
        wb_addr = rd;
        wb2d_a  = wb_we && (rd == d_inst[19:15]) && uses_rs1(d_inst[6:0], d_inst[14:12]);
        wb2d_b  = wb_we && (rd == d_inst[24:20]) && uses_rs2(d_inst[6:0]);
    end

    assign mw_inst       = inst_q;
    assign unused_d_inst = ^{d_inst[31:25], d_inst[11:7]};

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a queue-based scoreboard of expected MW outputs.
module tb_writeback_stage;

    logic        clk;
    logic        rst, stall, flush;
    logic [31:0] x2m_inst, x2m_pc, x2m_alu, dmem_dout, d_inst;
    logic        wb_we, wb2d_a, wb2d_b;
    logic [4:0]  wb_addr;
    logic [31:0] wb_val, mw_inst;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] val;
        logic        a;
        logic        b;
        logic [31:0] mw;
    } exp_t;

    exp_t sb[$];

    writeback_stage #(.DWIDTH(32), .NOP(32'h0000_0013)) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .x2m_inst  (x2m_inst),
        .x2m_pc    (x2m_pc),
        .x2m_alu   (x2m_alu),
        .dmem_dout (dmem_dout),
        .d_inst    (d_inst),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_val    (wb_val),
        .wb2d_a    (wb2d_a),
        .wb2d_b    (wb2d_b),
        .mw_inst   (mw_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs2, rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {7'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] stype(input logic [11:0] imm, input logic [4:0] rs2, rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, record the expected MW outputs, then compare after the edge.
    task automatic step(input string tag, input logic r, s, f,
                        input logic [31:0] inst, pc, alu, dmem, dinst,
                        input logic ewe, input logic [4:0] eaddr, input logic [31:0] evalue,
                        input logic ea, eb, input logic [31:0] emw);
        exp_t e;
        sb.push_back('{tag, ewe, eaddr, evalue, ea, eb, emw});
        rst      = r;
        stall    = s;
        flush    = f;
        x2m_inst = inst;
        x2m_pc   = pc;
        x2m_alu  = alu;
        @(posedge clk);
        #1;
        dmem_dout = dmem;
        d_inst    = dinst;
        #1;
        e = sb.pop_front();
        chk({e.tag, ".we"},   {31'b0, wb_we},  {31'b0, e.we});
        chk({e.tag, ".addr"}, {27'b0, wb_addr}, {27'b0, e.addr});
        chk({e.tag, ".val"},  wb_val,          e.val);
        chk({e.tag, ".a"},    {31'b0, wb2d_a}, {31'b0, e.a});
        chk({e.tag, ".b"},    {31'b0, wb2d_b}, {31'b0, e.b});
        chk({e.tag, ".mw"},   mw_inst,         e.mw);
    endtask

    localparam logic [31:0] NOPI = 32'h0000_0013;
    localparam logic [31:0] DMEM = 32'h8081_F27F;
    localparam logic [31:0] LDA  = 32'h1000_0002;

    logic [31:0] add5, add0, sw55, sw00, lui5, use10, jal1, addi7, addi8, use7;
    logic [31:0] csrrw5, csrrwi5, lb10, lbu10, lh10, lhu10, lw10, lx10, sw_st;

    initial begin
        add5    = rtype(5'd2, 5'd1, 3'b000, 5'd5);
        add0    = rtype(5'd2, 5'd1, 3'b000, 5'd0);
        sw55    = stype(12'h0, 5'd5, 5'd5, 3'b010);
        sw00    = stype(12'h0, 5'd0, 5'd0, 3'b010);
        sw_st   = stype(12'h0, 5'd3, 5'd4, 3'b010);
        lui5    = {20'h00001, 5'd5, 7'b0110111};
        use10   = rtype(5'd10, 5'd10, 3'b000, 5'd11);
        jal1    = {20'h0, 5'd1, 7'b1101111};
        addi7   = itype(12'd9, 5'd0, 3'b000, 5'd7, 7'b0010011);
        addi8   = itype(12'd5, 5'd0, 3'b000, 5'd8, 7'b0010011);
        use7    = itype(12'd1, 5'd7, 3'b000, 5'd8, 7'b0010011);
        csrrw5  = itype(12'h305, 5'd5, 3'b001, 5'd3, 7'b1110011);
        csrrwi5 = itype(12'h305, 5'd5, 3'b101, 5'd3, 7'b1110011);
        lb10    = itype(12'h0, 5'd11, 3'b000, 5'd10, 7'b0000011);
        lbu10   = itype(12'h0, 5'd11, 3'b100, 5'd10, 7'b0000011);
        lh10    = itype(12'h0, 5'd11, 3'b001, 5'd10, 7'b0000011);
        lhu10   = itype(12'h0, 5'd11, 3'b101, 5'd10, 7'b0000011);
        lw10    = itype(12'h0, 5'd11, 3'b010, 5'd10, 7'b0000011);
        lx10    = itype(12'h0, 5'd11, 3'b011, 5'd10, 7'b0000011);

        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        x2m_inst = NOPI; x2m_pc = '0; x2m_alu = '0; dmem_dout = '0; d_inst = NOPI;

        step("reset",    1, 0, 0, add5, 32'h100, 32'h55, 0, sw55, 0, 5'd0, 32'h0, 0, 0, NOPI);

        step("lb",       0, 0, 0, lb10,  32'h200, LDA, DMEM, use10, 1, 5'd10, 32'hFFFF_FF81, 1, 1, lb10);
        step("lbu",      0, 0, 0, lbu10, 32'h204, LDA, DMEM, NOPI,  1, 5'd10, 32'h0000_0081, 0, 0, lbu10);
        step("lh",       0, 0, 0, lh10,  32'h208, LDA, DMEM, NOPI,  1, 5'd10, 32'hFFFF_8081, 0, 0, lh10);
        step("lhu",      0, 0, 0, lhu10, 32'h20C, 32'h1000_0000, DMEM, NOPI, 1, 5'd10, 32'h0000_F27F, 0, 0, lhu10);
        step("lb_off3",  0, 0, 0, lb10,  32'h210, 32'h1000_0003, DMEM, NOPI, 1, 5'd10, 32'hFFFF_FF80, 0, 0, lb10);
        step("lh_odd",   0, 0, 0, lh10,  32'h214, 32'h1000_0001, DMEM, NOPI, 1, 5'd10, 32'hFFFF_F27F, 0, 0, lh10);
        step("lw",       0, 0, 0, lw10,  32'h218, 32'h1000_0003, DMEM, NOPI, 1, 5'd10, DMEM, 0, 0, lw10);
        step("lx_f3",    0, 0, 0, lx10,  32'h21C, 32'h1000_0001, DMEM, NOPI, 1, 5'd10, DMEM, 0, 0, lx10);

        step("jal",      0, 0, 0, jal1, 32'h0000_1FFC, 32'hDEAD, 0, NOPI, 1, 5'd1, 32'h0000_2000, 0, 0, jal1);
        step("jal_wrap", 0, 0, 0, jal1, 32'hFFFF_FFFC, 32'hDEAD, 0, NOPI, 1, 5'd1, 32'h0000_0000, 0, 0, jal1);

        step("fwd_sw",   0, 0, 0, add5, 32'h300, 32'h1234, 0, sw55,    1, 5'd5, 32'h1234, 1, 1, add5);
        step("fwd_lui",  0, 0, 0, add5, 32'h304, 32'h1234, 0, lui5,    1, 5'd5, 32'h1234, 0, 0, add5);
        step("fwd_csr",  0, 0, 0, add5, 32'h308, 32'h1234, 0, csrrw5,  1, 5'd5, 32'h1234, 1, 0, add5);
        step("fwd_csri", 0, 0, 0, add5, 32'h30C, 32'h1234, 0, csrrwi5, 1, 5'd5, 32'h1234, 0, 0, add5);
        step("fwd_x0",   0, 0, 0, add0, 32'h310, 32'h1234, 0, sw00,    0, 5'd0, 32'h1234, 0, 0, add0);
        step("store",    0, 0, 0, sw_st, 32'h314, 32'h4000, 0, sw55,   0, 5'd0, 32'h4000, 0, 0, sw_st);

        step("stall_ld", 0, 0, 0, addi7, 32'h400, 32'd9, 0, use7, 1, 5'd7, 32'd9, 1, 0, addi7);
        for (int i = 0; i < 3; i++)
            step("stall",  0, 1, 0, addi8, 32'h404, 32'd5, 0, use7, 1, 5'd7, 32'd9, 1, 0, addi7);
        step("stall_rel",0, 0, 0, addi8, 32'h404, 32'd5, 0, use7, 1, 5'd8, 32'd5, 0, 0, addi8);

        step("flush_st", 0, 1, 1, sw55, 32'h408, 32'h77, 0, NOPI, 0, 5'd0, 32'h0, 0, 0, NOPI);

        step("pre_rst",  0, 0, 0, add5, 32'h500, 32'h99, 0, sw55, 1, 5'd5, 32'h99, 1, 1, add5);
        step("mid_rst",  1, 0, 0, jal1, 32'h504, 32'h99, 0, sw55, 0, 5'd0, 32'h0, 0, 0, NOPI);

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: observed %0d entries left expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final (MW) pipeline stage of the RISC-V core, the write side of the register file. It registers the instruction and results leaving execute, selects the writeback value, and sign/zero-extends and aligns load data from synchronous DMEM. It drives the regfile write port and produces the MW→D forwarding selects (`wb2d_a`, `wb2d_b`) and `wb_val` consumed by decode-stage operand read.

## Interface
Parameters:
- `DWIDTH`, 32: datapath width; only 32 is supported.
- `NOP`, 32'h0000_0013: instruction loaded into the MW register on reset or flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1: core clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `stall`  in  1: hold the MW register.
- `flush`  in  1: load `NOP` into the MW register on the next edge.
- `x2m_inst`  in  32: instruction leaving execute.
- `x2m_pc`  in  32: PC of `x2m_inst`.
- `x2m_alu`  in  32: ALU result, which is also the load address.
- `dmem_dout`  in  32: DMEM read word. Valid in the cycle the load occupies MW; the address was presented in the X cycle.
- `d_inst`  in  32: instruction currently in decode.
- `wb_we`  out  1: regfile write enable.
- `wb_addr`  out  5: regfile write address (`rd`).
- `wb_val`  out  32: regfile write data; also the forwarding value.
- `wb2d_a`  out  1: forward `wb_val` to decode `rs1`.
- `wb2d_b`  out  1: forward `wb_val` to decode `rs2`.
- `mw_inst`  out  32: registered MW instruction, for CSR and debug.

## Operation
- MW register: holds `inst`, `pc` and `alu`. Update priority is `rst` > `flush` > `stall` > load.
  - Reset or flush: inst = `NOP`, pc = 0, alu = 0.
  - `stall`: all three fields hold.
  - Otherwise: load the `x2m_*` values.
- Writeback select, by MW opcode:
  - LOAD: extended load data.
  - JAL, JALR: pc + 4 (32-bit, wraps).
  - LUI, AUIPC, OP, OP-IMM: alu.
  - STORE, BRANCH, SYSTEM/CSR, unknown opcode: no write. `wb_we`=0, and `wb_val` = alu (don't-care).
- `wb_we` = (opcode writes rd) && (rd != 0).
- `wb_addr` = inst[11:7].
- Load extension, with `off` = alu[1:0]:
  - `lb`/`lbu`: byte `dmem_dout[8*off +: 8]`, sign- or zero-extended.
  - `lh`/`lhu`: halfword selected by alu[1]; alu[0] is ignored, no trap.
  - `lw`: the whole word; alu[1:0] is ignored.
  - Undefined funct3: treated as `lw`.
- Forwarding:
  - `wb2d_a` = `wb_we` && (rd == d_inst[19:15]) && decode uses rs1. Rs1 users: OP, OP-IMM, LOAD, STORE, BRANCH, JALR, CSR funct3 001/010/011.
  - `wb2d_b` = `wb_we` && (rd == d_inst[24:20]) && decode uses rs2. Rs2 users: OP, STORE, BRANCH.
  - Never asserted for rd=x0.
- Stall interaction: the MW contents and forwarding stay live. `dmem_dout` must be held by the memory interface during a stall; this block does not capture it.

## Timing
- Outputs after reset (the NOP is in MW): `wb_we`=0, `wb_addr`=0, `wb_val`=0, `wb2d_a`=0, `wb2d_b`=0, `mw_inst`=`NOP`.
- Latency: an instruction presented on `x2m_*` at edge N drives `wb_*` during cycle N→N+1.
- `wb_*` outputs are combinational from the MW register plus `dmem_dout` (load path) and `d_inst` (forwarding path). No further registering.
- Regfile write occurs at the end of the MW cycle (edge N+1). Forwarding covers the same-cycle read in decode.
- `flush` and `stall` asserted together: flush wins, and NOP enters MW.
- `rst` asserted mid-stream: the in-flight instruction is discarded. No write occurs in the cycle after the reset edge.

## Structure
- Shared package `riscv_pkg`:
  - opcode constants (LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP_IMM, SYSTEM);
  - load funct3 constants (LB, LH, LW, LBU, LHU);
  - `NOP` encoding.
- One sub-module, `load_extend`: combinational alignment and extension. Inputs: funct3, addr[1:0], dmem_dout. Output: 32-bit load value.
- Forwarding compare and writeback mux stay in `writeback_stage`.

## Test plan
- Reset, then deassert: `wb_we`=0, `wb2d_a`=`wb2d_b`=0, `mw_inst`=32'h13 on the first cycle after the reset edge.
- Load extension with dmem_dout=32'h8081_F27F:
  - `lb`, alu=32'h1000_0002 → `wb_val`=32'hFFFF_FF81.
  - `lbu`, same address → 32'h0000_0081.
  - `lh`, alu[1:0]=2 → 32'hFFFF_8081.
  - `lhu`, alu[1:0]=0 → 32'h0000_F27F.
- `jal x1` at pc=32'h0000_1FFC → `wb_val`=32'h0000_2000, `wb_we`=1, `wb_addr`=1.
- Forwarding:
  - MW `add x5,..` with d_inst `sw x5,0(x5)` → `wb2d_a`=`wb2d_b`=1.
  - Same MW with d_inst `lui x5,1` → both 0.
  - MW writing x0 → both 0.
- Stall for 3 cycles with MW=`addi x7,x0,9`: `wb_val`=9 and `wb_we`=1 held each cycle; the next instruction appears only after `stall` drops.
- `flush` and `stall` both high with a `sw` on `x2m_inst` → `mw_inst`=32'h13 and `wb_we`=0 next cycle.
